// File: rtl/puf_pkg.sv
// puf_pkg: shared constants, state encoding and
// parameter sanity helpers for the PUF responder.
package puf_pkg;

  localparam int PUF_BLOCKS = 2;
  localparam int PUF_BITS   = 32 * PUF_BLOCKS;
  localparam int PUF_BYTES  = PUF_BITS / 8;
  localparam int PUF_ADDR_W = $clog2(PUF_BYTES);

  typedef enum logic [1:0] {
    WARMUP,
    SAMPLE,
    READY
  } puf_state_e;

  function automatic bit votes_ok(int v);
    return (v >= 1) && ((v % 2) == 1);
  endfunction

endpackage

// File: rtl/puf_array_responder_if.sv
// puf_array_responder_if: byte-read port between
// the key-generation reader and the PUF responder.
interface puf_array_responder_if #(
  parameter int ADDR_W = 3
);

  logic              puf_enable;
  logic [ADDR_W-1:0] puf_addr;
  logic [7:0]        puf_data;
  logic              puf_ready;

  modport master (
    output puf_enable,
    output puf_addr,
    input  puf_data,
    input  puf_ready
  );

  modport slave (
    input  puf_enable,
    input  puf_addr,
    output puf_data,
    output puf_ready
  );

endinterface

// File: rtl/tmv_voter.sv
// tmv_voter: temporal majority vote over VOTES
// consecutive raw samples of one PUF cell.
module tmv_voter #(
  parameter int VOTES = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic sample_en,
  input  logic raw_bit,
  output logic bit_done,
  output logic voted_bit,
  output logic unstable
);

  localparam int CW = $clog2(VOTES + 1);

  logic [CW-1:0] vote_cnt;
  logic [CW-1:0] ones_cnt;
  logic [CW-1:0] ones_tot;

  // Vote result includes the sample of the current cycle
  always_comb begin
    ones_tot  = ones_cnt + CW'(raw_bit);
    bit_done  = sample_en &&
                (vote_cnt == CW'(VOTES - 1));
    voted_bit = ones_tot > CW'(VOTES / 2);
    unstable  = (ones_tot != '0) &&
                (ones_tot != CW'(VOTES));
  end

  // Accumulate samples, restart after each bit
  always_ff @(posedge clk) begin
    if (reset) begin
      vote_cnt <= '0;
      ones_cnt <= '0;
    end else if (bit_done) begin
      vote_cnt <= '0;
      ones_cnt <= '0;
    end else if (sample_en) begin
      vote_cnt <= vote_cnt + 1'b1;
      ones_cnt <= ones_tot;
    end
  end

endmodule

// File: rtl/puf_array_responder.sv
// puf_array_responder: warm up, enroll a voted PUF
// response, then serve registered byte reads.
module puf_array_responder
  import puf_pkg::*;
#(
  parameter int PUF_BLOCKS    = puf_pkg::PUF_BLOCKS,
  parameter int VOTES         = 5,
  parameter int WARMUP_CYCLES = 16
) (
  input  logic                      puf_clk,
  input  logic                      reset,
  puf_array_responder_if.slave      bus,
  input  logic                      raw_bit,
  input  logic                      resample,
  output logic [$clog2(32*PUF_BLOCKS+1)-1:0] unstable_count
);

  localparam int BITS  = 32 * PUF_BLOCKS;
  localparam int BYTES = BITS / 8;
  localparam int AW    = $clog2(BYTES);
  localparam int IW    = $clog2(BITS);
  localparam int UW    = $clog2(BITS + 1);
  localparam int WW    = $clog2(WARMUP_CYCLES + 1);

  if (!votes_ok(VOTES)) begin : g_bad_votes
    $error("VOTES must be odd and >= 1");
  end
  if (WARMUP_CYCLES < 1) begin : g_bad_warm
    $error("WARMUP_CYCLES must be >= 1");
  end

  puf_state_e    state_q;
  puf_state_e    state_d;
  logic [WW-1:0] warm_cnt;
  logic [IW-1:0] bit_idx;
  logic [7:0]    mem [BYTES];

  logic sample_en;
  logic bit_done;
  logic voted_bit;
  logic unstable;
  logic warm_end;
  logic last_bit;
  logic samp_start;
  logic in_range;

  assign sample_en  = (state_q == SAMPLE);
  assign warm_end   = (warm_cnt == WW'(WARMUP_CYCLES - 1));
  assign last_bit   = (bit_idx == IW'(BITS - 1));
  assign samp_start = (state_d == SAMPLE) &&
                      (state_q != SAMPLE);
  assign in_range   = {1'b0, bus.puf_addr} <
                      (AW + 1)'(BYTES);
  assign bus.puf_ready = (state_q == READY);

  tmv_voter #(
    .VOTES (VOTES)
  ) u_voter (
    .clk       (puf_clk),
    .reset     (reset),
    .sample_en (sample_en),
    .raw_bit   (raw_bit),
    .bit_done  (bit_done),
    .voted_bit (voted_bit),
    .unstable  (unstable)
  );

  // Next-state: warmup, enrollment, serve, re-enroll
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WARMUP: if (warm_end) state_d = SAMPLE;
      SAMPLE: if (bit_done && last_bit) state_d = READY;
      READY:  if (resample) state_d = SAMPLE;
      default: state_d = WARMUP;
    endcase
  end

  // State register
  always_ff @(posedge puf_clk) begin
    if (reset) state_q <= WARMUP;
    else       state_q <= state_d;
  end

  // Warmup, bit index and unstable-bit counters
  always_ff @(posedge puf_clk) begin
    if (reset) begin
      warm_cnt       <= '0;
      bit_idx        <= '0;
      unstable_count <= '0;
    end else begin
      if (state_q == WARMUP)
        warm_cnt <= warm_cnt + 1'b1;
      if (samp_start) begin
        bit_idx        <= '0;
        unstable_count <= '0;
      end else if (bit_done) begin
        bit_idx <= last_bit ? '0 : bit_idx + 1'b1;
        if (unstable && (unstable_count != UW'(BITS)))
          unstable_count <= unstable_count + 1'b1;
      end
    end
  end

  // Register file: voted bits land LSB first
  always_ff @(posedge puf_clk) begin
    if (reset) begin
      for (int i = 0; i < BYTES; i++) mem[i] <= '0;
    end else if (bit_done) begin
      mem[bit_idx[IW-1:3]][bit_idx[2:0]] <= voted_bit;
    end
  end

  // Read port: data only from a complete response
  always_ff @(posedge puf_clk) begin
    if (reset) begin
      bus.puf_data <= '0;
    end else if (bus.puf_enable) begin
      if ((state_q == READY) && in_range)
        bus.puf_data <= mem[bus.puf_addr];
      else
        bus.puf_data <= '0;
    end
  end

endmodule

// File: tb/tb_puf_array_responder.sv
// tb_puf_array_responder: scoreboard bench for
// enrollment, read path, resample and reset.
module tb_puf_array_responder;
  import puf_pkg::*;

  localparam int NV = 5;
  localparam int NW = 16;
  localparam int NBITS = 64;
  localparam int NS = NBITS * NV;

  logic       puf_clk = 1'b0;
  logic       reset = 1'b1;
  logic       raw_bit = 1'b0;
  logic       resample = 1'b0;
  logic [6:0] unstable_count;

  puf_array_responder_if #(.ADDR_W(3)) bus ();

  puf_array_responder #(
    .PUF_BLOCKS    (2),
    .VOTES         (NV),
    .WARMUP_CYCLES (NW)
  ) dut (
    .puf_clk        (puf_clk),
    .reset          (reset),
    .bus            (bus),
    .raw_bit        (raw_bit),
    .resample       (resample),
    .unstable_count (unstable_count)
  );

  always #5 puf_clk = ~puf_clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] sb[$];
  logic       rd_v = 1'b0;

  task automatic check(string tag,
                       logic [31:0] obs,
                       logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, obs, exp);
    end
  endtask

  always @(posedge puf_clk) rd_v <= bus.puf_enable;

  always @(negedge puf_clk) begin
    logic [7:0] e;
    if (rd_v) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("read", {24'd0, bus.puf_data}, {24'd0, e});
      end
    end
  end

  function automatic logic raw_fn(int mode, int i);
    int b;
    int s;
    logic v;
    b = i / NV;
    s = i % NV;
    v = 1'b0;
    case (mode)
      0: v = 1'b1;
      1: v = (b % 2) == 1;
      2: v = ((b % 2) == 1) ^ ((s == 0) || (s == 3));
      3: v = (b % 2) == 0;
      default: v = 1'b0;
    endcase
    return v;
  endfunction

  function automatic int ones_of(int mode, int b);
    int n;
    n = 0;
    for (int s = 0; s < NV; s++)
      n += int'(raw_fn(mode, b * NV + s));
    return n;
  endfunction

  function automatic logic [7:0] exp_byte(int mode, int k);
    logic [7:0] v;
    v = '0;
    for (int j = 0; j < 8; j++)
      v[j] = ones_of(mode, k * 8 + j) > NV / 2;
    return v;
  endfunction

  function automatic int exp_unst(int mode, int nb);
    int n;
    n = 0;
    for (int b = 0; b < nb; b++)
      if (ones_of(mode, b) != 0 && ones_of(mode, b) != NV)
        n++;
    return n;
  endfunction

  task automatic do_reset();
    bus.puf_enable = 1'b0;
    reset = 1'b1;
    @(negedge puf_clk);
    @(negedge puf_clk);
    reset = 1'b0;
  endtask

  task automatic warmup(bit rd);
    for (int i = 0; i < NW; i++) begin
      bus.puf_enable = rd;
      bus.puf_addr = 3'd3;
      if (rd) sb.push_back(8'h00);
      @(negedge puf_clk);
    end
    bus.puf_enable = 1'b0;
  endtask

  task automatic enroll(int mode, int rd, int n);
    for (int i = 0; i < n; i++) begin
      raw_bit = raw_fn(mode, i);
      bus.puf_enable = (rd != 0);
      bus.puf_addr = (rd == 1) ? 3'd3 : 3'(i % 8);
      if (rd != 0) sb.push_back(8'h00);
      if (i == NS - 1)
        check("ready_early", {31'd0, bus.puf_ready}, 32'd0);
      @(negedge puf_clk);
    end
    bus.puf_enable = 1'b0;
    if (n == NS)
      check("ready_rise", {31'd0, bus.puf_ready}, 32'd1);
  endtask

  task automatic do_read(int a, logic [7:0] exp);
    bus.puf_enable = 1'b1;
    bus.puf_addr = 3'(a);
    sb.push_back(exp);
    @(negedge puf_clk);
    bus.puf_enable = 1'b0;
  endtask

  task automatic read_all(int mode);
    for (int k = 0; k < 8; k++) do_read(k, exp_byte(mode, k));
    @(negedge puf_clk);
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    bus.puf_enable = 1'b0;
    bus.puf_addr = 3'd0;
    @(negedge puf_clk);
    @(negedge puf_clk);
    check("rst_ready", {31'd0, bus.puf_ready}, 32'd0);
    check("rst_data", {24'd0, bus.puf_data}, 32'd0);
    check("rst_unst", {25'd0, unstable_count}, 32'd0);

    // all-ones cells
    do_reset();
    warmup(1'b0);
    enroll(0, 0, NS);
    read_all(0);
    check("unst_ones", {25'd0, unstable_count},
          exp_unst(0, NBITS));

    // alternating cells, resample ignored in warmup
    do_reset();
    resample = 1'b1;
    warmup(1'b0);
    resample = 1'b0;
    enroll(1, 0, NS);
    read_all(1);
    check("unst_alt", {25'd0, unstable_count},
          exp_unst(1, NBITS));

    // noisy alternating cells, reads while not ready
    do_reset();
    warmup(1'b1);
    enroll(2, 1, NS);
    read_all(2);
    check("unst_noisy", {25'd0, unstable_count},
          exp_unst(2, NBITS));
    repeat (3) @(negedge puf_clk);
    check("data_hold", {24'd0, bus.puf_data},
          {24'd0, exp_byte(2, 7)});

    // resample together with a read of old data
    bus.puf_enable = 1'b1;
    bus.puf_addr = 3'd0;
    resample = 1'b1;
    sb.push_back(exp_byte(2, 0));
    @(negedge puf_clk);
    resample = 1'b0;
    bus.puf_enable = 1'b0;
    check("resamp_ready", {31'd0, bus.puf_ready}, 32'd0);
    enroll(3, 2, NS);
    read_all(3);
    check("unst_inv", {25'd0, unstable_count},
          exp_unst(3, NBITS));

    // reset in the middle of enrollment
    do_read(0, exp_byte(3, 0));
    resample = 1'b1;
    @(negedge puf_clk);
    resample = 1'b0;
    enroll(2, 0, 100);
    check("mid_unst", {25'd0, unstable_count},
          exp_unst(2, 100 / NV));
    check("mid_data", {24'd0, bus.puf_data},
          {24'd0, exp_byte(3, 0)});
    reset = 1'b1;
    @(negedge puf_clk);
    reset = 1'b0;
    check("mrst_ready", {31'd0, bus.puf_ready}, 32'd0);
    check("mrst_data", {24'd0, bus.puf_data}, 32'd0);
    check("mrst_unst", {25'd0, unstable_count}, 32'd0);
    warmup(1'b0);
    enroll(1, 0, NS);
    read_all(1);

    repeat (2) @(negedge puf_clk);
    check("sb_drain", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/puf_array_responder.md
Name: puf_array_responder

Overview:
- Synthesizable responder side of the PUF clocked byte-read protocol (puf_clk / puf_enable / puf_addr -> puf_data) that the key-generation path issues.
- After reset it warms up, then enrolls a response by temporal-majority-voting (TMV) a raw PUF cell bit stream into a PUF_BYTES register file.
- It then serves byte reads with one-cycle registered latency.
- Used as the on-chip PUF front end and as the RTL stand-in for the PUF in system simulation.

Parameters:
- PUF_BLOCKS, 2, number of 32-bit PUF blocks; PUF_BITS = 32*PUF_BLOCKS, PUF_BYTES = PUF_BITS/8.
- VOTES, 5, raw samples per response bit; must be odd and >= 1.
- WARMUP_CYCLES, 16, puf_clk cycles of stabilization after reset before sampling; must be >= 1.

Ports:
- puf_clk, input, 1, block clock.
- reset, input, 1, synchronous, active-high.
- puf_enable, input, 1, read request for the current cycle.
- puf_addr, input, $clog2(PUF_BYTES), byte address.
- puf_data, output, 8, registered read data.
- raw_bit, input, 1, raw PUF cell output; sampled once per cycle in SAMPLE.
- resample, input, 1, single-cycle request to re-enroll.
- puf_ready, output, 1, high when the register file holds a complete voted response.
- unstable_count, output, $clog2(PUF_BITS+1), count of bits in the last enrollment whose votes were not unanimous.

Behaviour:
- Interface: reset is synchronous, active-high; the clock is puf_clk. All state changes on the rising edge of puf_clk.
- Reset values: puf_data = 0x00, puf_ready = 0, unstable_count = 0, register file all 0, state = WARMUP, all counters = 0.
- States: WARMUP -> SAMPLE -> READY; READY -> SAMPLE on resample.
- WARMUP:
  - warm counter increments each cycle.
  - At count WARMUP_CYCLES-1, go to SAMPLE; clear bit index, vote counter and unstable_count.
- SAMPLE:
  - Bit b (0..PUF_BITS-1) takes VOTES consecutive raw_bit samples; ones counter accumulates.
  - On the last sample, the voted bit = (ones > VOTES/2) is written to byte b/8, bit position b%8 (LSB first). The last sample itself is included in the vote.
  - If 0 < ones < VOTES, unstable_count increments, saturating at PUF_BITS.
  - After bit PUF_BITS-1 is written, go to READY; puf_ready = 1 from the next cycle.
  - SAMPLE duration is exactly PUF_BITS*VOTES cycles. First ready cycle = WARMUP_CYCLES + PUF_BITS*VOTES cycles after the first cycle with reset low.
- READY, read path:
  - If puf_enable, puf_data <= mem[puf_addr] when puf_addr < PUF_BYTES, else 0x00.
  - The data is visible after that edge; the reader samples it on its next puf_clk edge.
  - If puf_enable is low, puf_data holds its value.
- Reads when not READY: if puf_enable in WARMUP or SAMPLE, puf_data <= 0x00. No stall or handshake beyond puf_ready.
- resample:
  - Honoured only in READY; ignored in WARMUP and SAMPLE.
  - Next cycle: state = SAMPLE, puf_ready = 0, counters and unstable_count cleared.
  - Old bytes stay in the register file until each bit is overwritten, but are never readable before puf_ready returns to 1.
- resample and puf_enable in the same READY cycle: the read is served from the old data, then the transition to SAMPLE happens.
- Reset mid-operation, in any state: next cycle matches the reset values, including a cleared register file and a restarted warmup.
- Counter widths: bit index $clog2(PUF_BITS); vote and ones counters $clog2(VOTES+1); warm counter $clog2(WARMUP_CYCLES+1). No wrap is possible within legal ranges.

Decomposition:
- Shared package puf_pkg:
  - derived constants PUF_BITS, PUF_BYTES, PUF_ADDR_W;
  - state enum {WARMUP, SAMPLE, READY};
  - elaboration check that VOTES is odd.
- Sub-module tmv_voter (parameter VOTES):
  - inputs: clk, reset, sample_en, raw_bit;
  - outputs: bit_done pulse, voted_bit, unstable flag;
  - holds the vote and ones counters.
- Top level keeps the FSM, bit index, register file and read port.

Test Plan:
All scenarios use PUF_BLOCKS=2 (8 bytes), VOTES=5, WARMUP_CYCLES=16.
1. raw_bit=1 constant, release reset -> puf_ready rises after 336 cycles; reads of addr 0..7 return 0xFF each, one cycle after the enable edge; unstable_count=0.
2. raw_bit = b[0] of the current bit index -> all bytes read 0xAA; unstable_count=0.
3. Same as 2, but 2 of every 5 samples inverted -> all bytes still read 0xAA; unstable_count=64.
4. puf_enable=1, addr=3 during WARMUP and SAMPLE -> puf_data=0x00. In READY, enable low after a read of 0xAA -> puf_data holds 0xAA.
5. In READY with 0xAA loaded, pulse resample together with a read of addr 0, then drive raw_bit = ~b[0]:
   - the read returns 0xAA;
   - puf_ready=0 on the next cycle;
   - reads return 0x00 for 320 cycles;
   - afterwards all bytes read 0x55.
6. Assert reset for 1 cycle at SAMPLE cycle 100 -> puf_ready=0, puf_data=0x00, unstable_count=0, memory cleared; puf_ready rises again 336 cycles after reset is released.
